// File: rtl/ram_block_copy.sv
// Block move engine for a 1R1W synchronous-read RAM.
// Streams LEN words src->dst with a per-word copy/add/fill/xor transform.
module ram_block_copy #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  output logic                  done,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [WIDTH-1:0]      imm,
  output logic [ADDR_WIDTH-1:0] ram_raddr_0,
  input  logic [WIDTH-1:0]      ram_rdata_0,
  output logic [ADDR_WIDTH-1:0] ram_waddr_0,
  output logic                  ram_wen_0,
  output logic [WIDTH-1:0]      ram_wdata_0
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [WIDTH-1:0]      imm_q, imm_d;
  logic [ADDR_WIDTH:0]   r_q, r_d;
  logic [ADDR_WIDTH-1:0] w_q, w_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  wen_q, wen_d;
  logic                  done_q, done_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      wdata_c;

  // Read data arrives in the write cycle, so the transform is combinational.
  always_comb begin
    wdata_c = ram_rdata_0;
    unique case (mode_q)
      2'd1:    wdata_c = ram_rdata_0 + imm_q;
      2'd2:    wdata_c = imm_q;
      2'd3:    wdata_c = ram_rdata_0 ^ imm_q;
      default: wdata_c = ram_rdata_0;
    endcase
  end

  assign ready       = (state_q == IDLE);
  assign done        = done_q;
  assign ram_raddr_0 = raddr_q;
  assign ram_waddr_0 = waddr_q;
  assign ram_wen_0   = wen_q;
  assign ram_wdata_0 = wen_q ? wdata_c : wdata_q;

  // Next-state: accept, read issue, write issue one cycle behind.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dst_d   = dst_q;
    len_d   = len_q;
    imm_d   = imm_q;
    r_d     = r_q;
    w_d     = w_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wen_d   = 1'b0;
    done_d  = done_q;
    wdata_d = wdata_q;
    if (wen_q) wdata_d = wdata_c;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          dst_d  = dst_base;
          len_d  = len;
          imm_d  = imm;
          done_d = (len == '0);
          if (len != '0) begin
            state_d = RUN;
            r_d     = '0;
            w_d     = '0;
            raddr_d = src_base;
          end
        end
      end
      RUN: begin
        wen_d   = 1'b1;
        waddr_d = dst_q + w_q;
        w_d     = w_q + 1'b1;
        if (r_q == len_q - 1'b1) begin
          state_d = FLUSH;
        end else begin
          r_d     = r_q + 1'b1;
          raddr_d = raddr_q + 1'b1;
        end
      end
      FLUSH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      imm_q   <= '0;
      r_q     <= '0;
      w_q     <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      imm_q   <= imm_d;
      r_q     <= r_d;
      w_q     <= w_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_ram_block_copy.sv
// Bench for ram_block_copy: RAM model, queue-based reference model,
// per-cycle compare plus directed and random block operations.
module tb_ram_block_copy;
  localparam int W  = 32;
  localparam int AW = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [AW:0]   len = '0;
  logic [W-1:0]  imm = '0;
  logic          ready, done, wen;
  logic [AW-1:0] raddr, waddr;
  logic [W-1:0]  rdata, wdata;

  ram_block_copy #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .done(done),
    .mode(mode), .src_base(src_base), .dst_base(dst_base), .len(len),
    .imm(imm), .ram_raddr_0(raddr), .ram_rdata_0(rdata),
    .ram_waddr_0(waddr), .ram_wen_0(wen), .ram_wdata_0(wdata)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    rdata <= mem[raddr];
    if (wen) mem[waddr] = wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] xf(input int m, input logic [W-1:0] x,
                                      input logic [W-1:0] k);
    case (m)
      1:       return x + k;
      2:       return k;
      3:       return x ^ k;
      default: return x;
    endcase
  endfunction

  typedef struct {
    int           e;
    int           a;
    logic [W-1:0] d;
  } wr_t;

  wr_t          wq[$];
  logic [W-1:0] ref_mem [D];
  int           edge_n = 0;
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  int           m_end = 0;
  int           m_raddr = 0;
  int           m_rleft = 0;
  int           m_waddr = 0;
  logic [W-1:0] m_wdata = '0;

  // Reference: schedules the whole block's writes at accept time.
  always @(posedge clk or posedge rst) begin : model
    bit b0;
    int l;
    if (rst) begin
      wq.delete();
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_raddr = 0;
      m_rleft = 0;
      m_waddr = 0;
      m_wdata = '0;
    end else begin
      edge_n++;
      b0 = m_busy;
      if (wq.size() > 0 && wq[0].e == edge_n) begin
        ref_mem[wq[0].a] = wq[0].d;
        m_waddr = wq[0].a;
        m_wdata = wq[0].d;
        void'(wq.pop_front());
      end
      if (m_busy && edge_n == m_end) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
      if (m_rleft > 0) begin
        m_raddr = (m_raddr + 1) % D;
        m_rleft--;
      end
      if (!b0 && start) begin
        l = int'(len);
        m_done = (l == 0);
        if (l > 0) begin
          m_busy  = 1'b1;
          m_end   = edge_n + l + 1;
          m_raddr = int'(src_base);
          m_rleft = l - 1;
          for (int i = 0; i < l; i++)
            wq.push_back('{edge_n + 2 + i, (int'(dst_base) + i) % D,
                           xf(int'(mode), ref_mem[(int'(src_base) + i) % D],
                              imm)});
        end
      end
    end
  end

  // Every-cycle compare against the reference.
  always @(negedge clk) begin
    bit we;
    we = (wq.size() > 0 && wq[0].e == edge_n + 1);
    chk("ready", ready, m_busy ? 1'b0 : 1'b1);
    chk("done", done, m_done);
    chk("wen", wen, we);
    chk("raddr", raddr, m_raddr);
    if (we) begin
      chk("waddr", waddr, wq[0].a);
      chk("wdata", wdata, wq[0].d);
    end else begin
      chk("waddr_hold", waddr, m_waddr);
      chk("wdata_hold", wdata, m_wdata);
    end
  end

  int wen_total = 0;
  always @(negedge clk) if (wen === 1'b1) wen_total++;

  task automatic run_op(input int m, input int s, input int d, input int l,
                        input logic [W-1:0] k, input int pulse,
                        output int lat);
    int n;
    int w0;
    @(negedge clk);
    mode     = m[1:0];
    src_base = s[AW-1:0];
    dst_base = d[AW-1:0];
    len      = l[AW:0];
    imm      = k;
    start    = 1'b1;
    w0       = wen_total;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk("ready_after_accept", ready, (l == 0) ? 1'b1 : 1'b0);
    while (!(ready && done) && n < 40) begin
      @(negedge clk);
      n++;
      start = (n == pulse);
    end
    start = 1'b0;
    lat = n - 1;
    if (n >= 40) begin
      errors++;
      $display("FAIL timeout actual=%0d required=%0d", n, l + 2);
    end else begin
      chk("latency", lat, (l == 0) ? 0 : l + 1);
      chk("wen_count", wen_total - w0, l);
    end
  endtask

  initial begin
    int           lat;
    int           m, s, d, l, off, n;
    logic [W-1:0] pre [6];
    for (int i = 0; i < D; i++) begin
      mem[i]     = 3 * i;
      ref_mem[i] = 3 * i;
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_wen", wen, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", ready, 1'b1);
    chk("post_rst_done", done, 1'b0);

    run_op(0, 0, 8, 4, '0, 0, lat);
    chk("copy_lat", lat, 5);
    chk("copy_m8", mem[8], 0);
    chk("copy_m9", mem[9], 3);
    chk("copy_m10", mem[10], 6);
    chk("copy_m11", mem[11], 9);

    run_op(1, 1, 12, 2, 32'hFFFFFFFF, 0, lat);
    chk("add_lat", lat, 3);
    chk("add_m12", mem[12], 2);
    chk("add_m13", mem[13], 5);

    run_op(2, 4, 14, 4, 32'hA5, 0, lat);
    chk("fill_m14", mem[14], 32'hA5);
    chk("fill_m15", mem[15], 32'hA5);
    chk("fill_m0", mem[0], 32'hA5);
    chk("fill_m1", mem[1], 32'hA5);
    chk("fill_m2", mem[2], 6);

    run_op(0, 3, 5, 0, '0, 0, lat);
    chk("zero_lat", lat, 0);

    run_op(0, 4, 8, 4, '0, 2, lat);
    chk("busy_lat", lat, 5);
    chk("busy_m8", mem[8], 12);

    @(negedge clk);
    mode = 2'd0; src_base = 4'd2; dst_base = 4'd9; len = 5'd6; start = 1'b1;
    for (int i = 0; i < 6; i++) pre[i] = mem[9 + i];
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_wen", wen, 1'b0);
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_m9", mem[9], 6);
    chk("midrst_m10", mem[10], 9);
    for (int i = 2; i < 6; i++) chk("midrst_keep", mem[9 + i], pre[i]);

    run_op(0, 0, 4, 3, '0, 0, lat);
    chk("after_rst_m4", mem[4], 32'hA5);

    for (int t = 0; t < 25; t++) begin
      m = $urandom_range(0, 3);
      s = $urandom_range(0, D - 1);
      l = $urandom_range(0, D);
      do begin
        d = $urandom_range(0, D - 1);
        off = (d - s + D) % D;
      end while (off >= 1 && off <= l - 1);
      run_op(m, s, d, l, $urandom, 0, lat);
    end

    @(negedge clk);
    mode = 2'd1; src_base = 4'd0; dst_base = 4'd8; len = 5'd3;
    imm = 32'h1; start = 1'b1;
    repeat (25) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(ready && done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      errors++;
      $display("FAIL held_timeout actual=%0d required=%0d", n, 4);
    end

    for (int i = 0; i < D; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
